// File: rtl/breakout_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// breakout_game_ctrl_if
//
// Purpose: bundles the game-sequencing controller's event inputs and its
// status/score outputs so the controller, the graph/text units and the
// testbench share one port list.
//
// Signals:
//   start      master -> slave  start/serve key level
//   hit        master -> slave  paddle-hit level from the graph unit
//   miss       master -> slave  ball-lost level from the graph unit
//   state      slave -> master  2-bit game state (00 NEWGAME .. 11 OVER)
//   gra_still  slave -> master  1 = freeze ball/paddle motion
//   dig0/dig1  slave -> master  BCD score, ones / tens
//   balls      slave -> master  remaining lives
//   timer_busy slave -> master  pause timer running
//   score_wrap slave -> master  one-cycle pulse on 99 -> 00
//   hiscore    slave -> master  BCD high score (00 unless enabled)
//
// The slave modport is the controller; the master modport is whatever
// produces the key/hit/miss levels and consumes the status.
// -----------------------------------------------------------------------------
interface breakout_game_ctrl_if;
    logic       start;
    logic       hit;
    logic       miss;
    logic [1:0] state;
    logic       gra_still;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [1:0] balls;
    logic       timer_busy;
    logic       score_wrap;
    logic [7:0] hiscore;

    modport master (
        output start, hit, miss,
        input  state, gra_still, dig0, dig1, balls,
               timer_busy, score_wrap, hiscore
    );

    modport slave (
        input  start, hit, miss,
        output state, gra_still, dig0, dig1, balls,
               timer_busy, score_wrap, hiscore
    );
endinterface

// File: rtl/breakout_game_ctrl.sv
// -----------------------------------------------------------------------------
// breakout_game_ctrl
//
// Purpose: game-sequencing controller for the breakout/pong datapath. Freezes
// or releases the graphics engine, counts lives, keeps a two-digit BCD score
// and times the pauses between balls and after game over.
//
// Ports:
//   clk    system clock
//   rstn   asynchronous, active-low reset
//   bus    breakout_game_ctrl_if.slave
//            in : start, hit, miss           (levels, synchronous to clk)
//            out: state, gra_still, dig0, dig1, balls, timer_busy,
//                 score_wrap, hiscore        (all registered)
//
// Parameters:
//   BALLS_INIT      lives loaded at game start (1..3)
//   TIMEOUT_CYCLES  length of the NEWBALL/OVER pause in clk cycles (>= 2)
//
// Build option:
//   BREAKOUT_HISCORE_EN  when defined, keeps a BCD high score updated at the
//                        end of each game; otherwise hiscore is tied to 00.
// -----------------------------------------------------------------------------
module breakout_game_ctrl #(
    parameter int unsigned BALLS_INIT     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic                 clk,
    input  logic                 rstn,
    breakout_game_ctrl_if.slave  bus
);

    localparam int unsigned    TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     BALLS_RST  = 2'(BALLS_INIT);

    typedef enum logic [1:0] {
        S_NEWGAME = 2'b00,
        S_PLAY    = 2'b01,
        S_NEWBALL = 2'b10,
        S_OVER    = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         state_q,      state_d;
    logic           gra_still_q,  gra_still_d;
    logic [3:0]     dig0_q,       dig0_d;
    logic [3:0]     dig1_q,       dig1_d;
    logic [1:0]     balls_q,      balls_d;
    logic [TW-1:0]  timer_q,      timer_d;
    logic           timer_busy_q, timer_busy_d;
    logic           score_wrap_q, score_wrap_d;

    // Previous-cycle copies of the input levels for edge detection.
    logic           start_dly_q;
    logic           hit_dly_q;
    logic           miss_dly_q;

    logic           start_e;
    logic           hit_e;
    logic           miss_e;
    logic           timer_load;

    // A level held high yields exactly one event: the cycle it first rises.
    assign start_e = bus.start & ~start_dly_q;
    assign hit_e   = bus.hit   & ~hit_dly_q;
    assign miss_e  = bus.miss  & ~miss_dly_q;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        dig0_d       = dig0_q;
        dig1_d       = dig1_q;
        balls_d      = balls_q;
        score_wrap_d = 1'b0;
        timer_load   = 1'b0;

        unique case (state_q)
            S_NEWGAME: begin
                if (start_e) begin
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                    balls_d = BALLS_RST;
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                // Hit and miss in the same cycle are both honoured: the
                // score increments and the miss is processed.
                if (hit_e) begin
                    if (dig0_q == 4'd9) begin
                        dig0_d = 4'd0;
                        if (dig1_q == 4'd9) begin
                            dig1_d       = 4'd0;
                            score_wrap_d = 1'b1;
                        end else begin
                            dig1_d = dig1_q + 4'd1;
                        end
                    end else begin
                        dig0_d = dig0_q + 4'd1;
                    end
                end
                if (miss_e) begin
                    timer_load = 1'b1;
                    if (balls_q > 2'd1) begin
                        balls_d = balls_q - 2'd1;
                        state_d = S_NEWBALL;
                    end else begin
                        balls_d = 2'd0;
                        state_d = S_OVER;
                    end
                end
            end

            S_NEWBALL: begin
                // The serve key only counts once the pause has run out.
                if (start_e && !timer_busy_q) begin
                    state_d = S_PLAY;
                end
            end

            S_OVER: begin
                // Score stays on display until the next game is started.
                if (!timer_busy_q) begin
                    state_d = S_NEWGAME;
                end
            end

            default: state_d = S_NEWGAME;
        endcase

        // Pause timer: busy stays high through the cycle the count reaches 0
        // and drops on the edge after, giving TIMEOUT_CYCLES busy cycles.
        if (timer_load) begin
            timer_d      = TIMER_LOAD;
            timer_busy_d = 1'b1;
        end else begin
            timer_d      = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
            timer_busy_d = (timer_q != '0);
        end

        // Registered from the next state so it moves together with state.
        gra_still_d = (state_d != S_PLAY);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_NEWGAME;
            gra_still_q  <= 1'b1;
            dig0_q       <= 4'd0;
            dig1_q       <= 4'd0;
            balls_q      <= BALLS_RST;
            timer_q      <= '0;
            timer_busy_q <= 1'b0;
            score_wrap_q <= 1'b0;
            start_dly_q  <= 1'b0;
            hit_dly_q    <= 1'b0;
            miss_dly_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gra_still_q  <= gra_still_d;
            dig0_q       <= dig0_d;
            dig1_q       <= dig1_d;
            balls_q      <= balls_d;
            timer_q      <= timer_d;
            timer_busy_q <= timer_busy_d;
            score_wrap_q <= score_wrap_d;
            start_dly_q  <= bus.start;
            hit_dly_q    <= bus.hit;
            miss_dly_q   <= bus.miss;
        end
    end

    // ------------------------------------------------------------------
    // High score
    // ------------------------------------------------------------------
`ifdef BREAKOUT_HISCORE_EN
    logic [7:0] hiscore_q;

    // Packed BCD compares correctly as plain binary: tens nibble dominates.
    // The final score of the game (after any same-cycle hit) is recorded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hiscore_q <= 8'h00;
        end else if ((state_q == S_PLAY) && (state_d == S_OVER) &&
                     ({dig1_d, dig0_d} > hiscore_q)) begin
            hiscore_q <= {dig1_d, dig0_d};
        end
    end

    assign bus.hiscore = hiscore_q;
`else
    assign bus.hiscore = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.state      = state_q;
    assign bus.gra_still  = gra_still_q;
    assign bus.dig0       = dig0_q;
    assign bus.dig1       = dig1_q;
    assign bus.balls      = balls_q;
    assign bus.timer_busy = timer_busy_q;
    assign bus.score_wrap = score_wrap_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_breakout_game_ctrl
//
// Self-checking bench for breakout_game_ctrl (TIMEOUT_CYCLES=16, BALLS_INIT=3).
// A game-level model (integer score 0..99, integer lives, remaining pause
// cycles) is advanced once per clock; a compare process checks every DUT
// output against it on each falling edge. Directed scenarios add literal
// expectations, then a randomized phase exercises arbitrary input levels.
// -----------------------------------------------------------------------------
module tb_breakout_game_ctrl;

    localparam int T_CYC = 16;
    localparam int BALLS = 3;
`ifdef BREAKOUT_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    localparam int M_NEWGAME = 0;
    localparam int M_PLAY    = 1;
    localparam int M_NEWBALL = 2;
    localparam int M_OVER    = 3;

    logic clk;
    logic rstn;

    breakout_game_ctrl_if bus_if ();

    breakout_game_ctrl #(
        .BALLS_INIT     (BALLS),
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard counters and check task
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural game model
    // ------------------------------------------------------------------
    int m_state     = M_NEWGAME;
    int m_score     = 0;
    int m_balls     = BALLS;
    int m_busy_left = 0;   // remaining cycles timer_busy is shown high
    int m_wrap      = 0;
    int m_hi        = 0;
    bit m_ps = 0, m_ph = 0, m_pm = 0;

    task automatic model_reset();
        m_state     = M_NEWGAME;
        m_score     = 0;
        m_balls     = BALLS;
        m_busy_left = 0;
        m_wrap      = 0;
        m_hi        = 0;
        m_ps        = 0;
        m_ph        = 0;
        m_pm        = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit m);
        bit se, he, me, busy, load;
        se   = s && !m_ps;
        he   = h && !m_ph;
        me   = m && !m_pm;
        m_ps = s; m_ph = h; m_pm = m;
        busy = (m_busy_left > 0);
        load = 0;
        m_wrap = 0;
        case (m_state)
            M_NEWGAME: if (se) begin
                m_score = 0;
                m_balls = BALLS;
                m_state = M_PLAY;
            end
            M_PLAY: begin
                if (he) begin
                    m_score = m_score + 1;
                    if (m_score == 100) begin
                        m_score = 0;
                        m_wrap  = 1;
                    end
                end
                if (me) begin
                    load = 1;
                    if (m_balls > 1) begin
                        m_balls = m_balls - 1;
                        m_state = M_NEWBALL;
                    end else begin
                        m_balls = 0;
                        m_state = M_OVER;
                        if (HI_EN && m_score > m_hi) m_hi = m_score;
                    end
                end
            end
            M_NEWBALL: if (se && !busy) m_state = M_PLAY;
            default:   if (!busy) m_state = M_NEWGAME;
        endcase
        if (load)                 m_busy_left = T_CYC;
        else if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
    endtask

    // ------------------------------------------------------------------
    // Compare process: every falling edge, all outputs
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("state",      32'(bus_if.state),      32'(m_state));
        check("gra_still",  32'(bus_if.gra_still),  32'(m_state != M_PLAY));
        check("dig0",       32'(bus_if.dig0),       32'(m_score % 10));
        check("dig1",       32'(bus_if.dig1),       32'(m_score / 10));
        check("balls",      32'(bus_if.balls),      32'(m_balls));
        check("timer_busy", 32'(bus_if.timer_busy), 32'(m_busy_left > 0));
        check("score_wrap", 32'(bus_if.score_wrap), 32'(m_wrap));
        check("hiscore",    32'(bus_if.hiscore),    32'(((m_hi / 10) << 4) | (m_hi % 10)));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a falling edge)
    // ------------------------------------------------------------------
    task automatic cycle(input bit s, input bit h, input bit m);
        bus_if.start = s;
        bus_if.hit   = h;
        bus_if.miss  = m;
        @(posedge clk);
        model_step(s, h, m);
        @(negedge clk);
        #1;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
    endtask

    task automatic wait_pause();
        for (int i = 0; i < 4 * T_CYC && bus_if.timer_busy; i++) cycle(0, 0, 0);
        check("pause_bound", 32'(bus_if.timer_busy), 32'd0);
    endtask

    task automatic serve();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n_busy;
        logic [7:0] hi_exp;
        hi_exp = HI_EN ? 8'h12 : 8'h00;

        rstn = 1'b0;
        bus_if.start = 1'b0;
        bus_if.hit   = 1'b0;
        bus_if.miss  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_state",   32'(bus_if.state),      32'd0);
        check("rst_still",   32'(bus_if.gra_still),  32'd1);
        check("rst_balls",   32'(bus_if.balls),      32'd3);
        check("rst_busy",    32'(bus_if.timer_busy), 32'd0);
        check("rst_hiscore", 32'(bus_if.hiscore),    32'd0);
        rstn = 1'b1;

        // Start held for five cycles: exactly one transition to PLAY.
        cycle(1, 0, 0);
        check("start_play",  32'(bus_if.state),     32'd1);
        check("start_still", 32'(bus_if.gra_still), 32'd0);
        check("start_balls", 32'(bus_if.balls),     32'd3);
        repeat (4) cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("start_once",  32'(bus_if.state),     32'd1);

        // Score counting and wrap.
        hits(10);
        check("score10", 32'({bus_if.dig1, bus_if.dig0}), 32'h10);
        hits(89);
        check("score99", 32'({bus_if.dig1, bus_if.dig0}), 32'h99);
        cycle(0, 1, 0);
        check("wrap_score", 32'({bus_if.dig1, bus_if.dig0}), 32'h00);
        check("wrap_pulse", 32'(bus_if.score_wrap), 32'd1);
        cycle(0, 0, 0);
        check("wrap_clear", 32'(bus_if.score_wrap), 32'd0);

        // Miss with three lives; early serve ignored; pause length.
        cycle(0, 0, 1);
        check("miss_state", 32'(bus_if.state), 32'd2);
        check("miss_balls", 32'(bus_if.balls), 32'd2);
        n_busy = bus_if.timer_busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            if (bus_if.timer_busy) n_busy++;
        end
        cycle(1, 0, 0);
        if (bus_if.timer_busy) n_busy++;
        check("early_serve", 32'(bus_if.state), 32'd2);
        for (int i = 0; i < 4 * T_CYC && bus_if.timer_busy; i++) begin
            cycle(0, 0, 0);
            if (bus_if.timer_busy) n_busy++;
        end
        check("busy_len", 32'(n_busy), 32'd16);
        serve();
        check("serve_play", 32'(bus_if.state), 32'd1);

        // Last life: hit and miss together, game 1 ends at 12.
        cycle(0, 0, 1);
        wait_pause();
        serve();
        check("last_life", 32'(bus_if.balls), 32'd1);
        hits(11);
        cycle(0, 1, 1);
        check("over_state", 32'(bus_if.state), 32'd3);
        check("over_balls", 32'(bus_if.balls), 32'd0);
        check("over_score", 32'({bus_if.dig1, bus_if.dig0}), 32'h12);
        check("hi_game1",   32'(bus_if.hiscore), 32'(hi_exp));
        wait_pause();
        cycle(0, 0, 0);
        check("back_newgame", 32'(bus_if.state), 32'd0);
        check("held_score",   32'({bus_if.dig1, bus_if.dig0}), 32'h12);
        serve();
        check("new_score", 32'({bus_if.dig1, bus_if.dig0}), 32'h00);
        check("new_balls", 32'(bus_if.balls), 32'd3);

        // Game 2 ends at 07: high score unchanged.
        hits(7);
        for (int b = 0; b < 2; b++) begin
            cycle(0, 0, 1);
            wait_pause();
            serve();
        end
        cycle(0, 0, 1);
        check("over2_score", 32'({bus_if.dig1, bus_if.dig0}), 32'h07);
        check("hi_game2",    32'(bus_if.hiscore), 32'(hi_exp));
        wait_pause();
        cycle(0, 0, 0);

        // Asynchronous reset in the middle of a NEWBALL pause.
        serve();
        cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 0);
        rstn = 1'b0;
        model_reset();
        #1;
        check("mid_rst_state", 32'(bus_if.state),      32'd0);
        check("mid_rst_busy",  32'(bus_if.timer_busy), 32'd0);
        check("mid_rst_balls", 32'(bus_if.balls),      32'd3);
        check("mid_rst_still", 32'(bus_if.gra_still),  32'd1);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) cycle(0, 0, 0);
        check("post_rst_idle", 32'(bus_if.state), 32'd0);

        // Randomized levels against the model, with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                rstn = 1'b0;
                model_reset();
                #2;
                rstn = 1'b1;
            end
            cycle(bit'($urandom_range(0, 7) == 0),
                  bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 24) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
